// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder, one operand bit per clock, LSB first.
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | adding one bit per clock, WIDTH clocks
// DONE  | one-cycle done pulse, then back to IDLE
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-2:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        fa_s     = sh_a[0] ^ sh_b[0] ^ carry;
        fa_c     = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
        res_next = {fa_s, res};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_next[WIDTH-1:1];
                    carry <= fa_c;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    if (cnt == LAST) begin
                        // carry reg still holds the carry into the MSB here
                        sum   <= res_next;
                        cout  <= fa_c;
                        ovf   <= carry ^ fa_c;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one operation; operands are scrambled right after acceptance
    task automatic do_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(posedge clk);
        #1;
        a = ~va; b = ~vb; cin = ~vc;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 8);
        check_eq({tag, "_sum"}, sum, es);
        check_eq({tag, "_cout"}, cout, ec);
        check_eq({tag, "_ovf"}, ovf, eo);
        @(negedge clk);
        check_eq({tag, "_done_len"}, done, 0);
        check_eq({tag, "_busy_end"}, busy, 0);
        check_eq({tag, "_hold"}, sum, es);
    endtask

    initial begin
        int busy_n, done_n, wcnt, prev;
        logic [7:0] dsum, ra, rb;
        logic       rc;
        logic [8:0] full;
        logic       eovf;

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_sum", sum, 0);
        check_eq("rst_cout", cout, 0);
        check_eq("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        do_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("cinonly", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        do_op("ovfpos",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("ovfneg",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        do_op("allones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // second start during RUN must be ignored
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        busy_n = 0; done_n = 0; dsum = 8'h00;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 2) begin a = 8'h55; b = 8'h22; start = 1'b1; end
            if (k == 3) start = 1'b0;
            busy_n += int'(busy);
            done_n += int'(done);
            if (done) dsum = sum;
        end
        check_eq("ign_busy_cycles", busy_n, 9);
        check_eq("ign_done_count", done_n, 1);
        check_eq("ign_sum", dsum, 8'h10);

        // reset in the middle of RUN
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_sum", sum, 0);
        check_eq("abort_cout", cout, 0);
        done_n = 0;
        repeat (10) begin
            @(negedge clk);
            done_n += int'(done);
        end
        check_eq("abort_no_done", done_n, 0);
        rst_n = 1'b1;
        do_op("post_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        // start held high: back-to-back random operations
        @(negedge clk);
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        a = ra; b = rb; cin = rc; start = 1'b1;
        prev = 0;
        for (int n = 0; n < 1000; n++) begin
            wcnt = 0;
            while (!done && wcnt < 30) begin
                @(negedge clk);
                wcnt++;
            end
            if (!done) begin
                check_eq("rnd_timeout", 0, 1);
                break;
            end
            full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            eovf = (ra[7] == rb[7]) && (full[7] != ra[7]);
            check_eq("rnd_sum", sum, full[7:0]);
            check_eq("rnd_cout", cout, full[8]);
            check_eq("rnd_ovf", ovf, eovf);
            if (n > 0) check_eq("rnd_period", cyc - prev, 10);
            prev = cyc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            a = ra; b = rb; cin = rc;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request one addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port cin  input  1  carry in.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 SHALL have port done  output  1  single-cycle pulse; result valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result.
REQ-011 SHALL have port cout  output  1  carry out of MSB.
REQ-012 SHALL have port ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 SHALL use one 1-bit full adder, sum = x^y^c and carry = majority(x,y,c), applied to one bit per clock, LSB first.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 at edge E0 -> latch a, b into shift registers, carry reg <= cin, bit counter <= 0, state -> RUN.
REQ-016 IDLE: start=0 -> remain IDLE; a, b, cin ignored.
REQ-017 RUN: each edge, add shift-register LSBs plus carry reg, shift sum bit into result shift register from MSB, update carry reg, shift operands right, increment counter.
REQ-018 RUN: on edge where counter == WIDTH-1 (edge E0+WIDTH), state -> DONE; sum, cout, ovf registers load the final values on that same edge.
REQ-019 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1, captured when bit WIDTH-1 is processed.
REQ-020 DONE: done=1 for exactly one cycle, following edge E0+WIDTH; next edge -> IDLE.
REQ-021 busy SHALL be 1 in RUN and DONE, 0 in IDLE; busy rises the cycle after E0.
REQ-022 start while busy=1 (RUN or DONE) SHALL be ignored; no queuing.
REQ-023 Back-to-back: start held high SHALL be accepted in the first IDLE cycle after DONE; issue period = WIDTH+2 cycles.
REQ-024 sum, cout, ovf SHALL hold the last result until the next DONE entry; they SHALL NOT change during RUN.
REQ-025 Operand changes after E0 SHALL NOT affect the in-flight result.
REQ-026 Bit counter SHALL be $clog2(WIDTH) bits wide; it SHALL NOT wrap within one operation.
REQ-027 All arithmetic is modulo 2^WIDTH; the carry leaves only via cout.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter/shift/carry registers 0.
REQ-029 Reset during RUN or DONE SHALL abort the operation; no done pulse is produced for it.
REQ-030 After rst_n deasserts, the first rising edge with start=1 SHALL start a new operation normally.

Verification (WIDTH=8)
REQ-031 a=0x0F, b=0x01, cin=0, start pulse -> done exactly 9 cycles after start edge... more precisely done high in the cycle after edge E0+8; sum=0x10, cout=0, ovf=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, ovf=0.
REQ-033 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
REQ-034 start pulsed again at E0+3 with different operands -> ignored; single done with first result; busy high for 9 cycles.
REQ-035 rst_n low at E0+4 -> all outputs 0 immediately, no done; next start a=0x03, b=0x04 -> sum=0x07.
REQ-036 start held high continuously -> done pulses every 10 cycles; random a, b, cin over 1000 ops match (a+b+cin) mod 256 with correct cout and ovf.
